// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter plus IDLE/GRANT sequencer sharing one n-bit register among R requesters.
// Optional ARB_LOCK_EN: a locked winner may keep the grant for up to MAX_LOCK consecutive writes.
module reg_write_arbiter #(
    parameter int n        = 16,
    parameter int R        = 4,
    parameter int MAX_LOCK = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [R-1:0]   req,
    input  logic [R*n-1:0] in0,
    input  logic [R-1:0]   lock,
    output logic [R-1:0]   gnt,
    output logic [R-1:0]   ack,
    output logic [n-1:0]   out0,
    output logic           busy
);
    localparam int PW = (R > 1) ? $clog2(R) : 1;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t        state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] w;
    logic [PW-1:0] win;
    logic [PW-1:0] idx;
    logic          win_vld;
    logic [n-1:0]  slice [R];

    for (genvar i = 0; i < R; i++) begin : g_slice
        assign slice[i] = in0[i*n +: n];
    end

    function automatic logic [PW-1:0] rr_idx(input logic [PW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= R) s = s - R;
        return PW'(s);
    endfunction

    // Scan from the farthest offset down so the requester closest to ptr wins.
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        idx     = '0;
        for (int k = R - 1; k >= 0; k--) begin
            idx = rr_idx(ptr, k);
            if (req[idx]) begin
                win     = idx;
                win_vld = 1'b1;
            end
        end
    end

`ifdef ARB_LOCK_EN
    localparam int CW = (MAX_LOCK > 1) ? $clog2(MAX_LOCK) : 1;
    logic [CW-1:0] lcnt;
    logic          hold;
    assign hold = req[w] && lock[w] && (lcnt < CW'(MAX_LOCK - 1));
`else
    logic unused_lock;
    assign unused_lock = ^lock;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
            w     <= '0;
            gnt   <= '0;
            ack   <= '0;
            out0  <= '0;
            busy  <= 1'b0;
`ifdef ARB_LOCK_EN
            lcnt  <= '0;
`endif
        end else begin
            ack <= '0;
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        w     <= win;
                        gnt   <= {{(R-1){1'b0}}, 1'b1} << win;
                        state <= GRANT;
                        busy  <= 1'b1;
                    end
                end
                GRANT: begin
                    // A withdrawn requester loses its slot without writing.
                    if (req[w]) begin
                        out0 <= slice[w];
                        ack  <= gnt;
                    end
`ifdef ARB_LOCK_EN
                    if (hold) begin
                        lcnt <= lcnt + 1'b1;
                    end else begin
                        lcnt  <= '0;
                        ptr   <= (w == PW'(R - 1)) ? '0 : w + 1'b1;
                        gnt   <= '0;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
`else
                    ptr   <= (w == PW'(R - 1)) ? '0 : w + 1'b1;
                    gnt   <= '0;
                    state <= IDLE;
                    busy  <= 1'b0;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/reg_write_arbiter.md
Name: reg_write_arbiter

Overview:
- Shares one N-bit storage register among R requesters: a round-robin arbiter plus a two-state sequencer.
- Each requester presents a write request and data. The arbiter grants one requester, loads its data into the shared register and returns a one-cycle acknowledge.
- Sits in front of the N-bit register used across the datapath labs. It replaces direct multi-driver writes with a single arbitrated write port.

Parameters:
- n, 16, data width of the shared register and of each requester's data slice
- R, 4, number of requesters (2..8)
- MAX_LOCK, 8, maximum consecutive writes under lock before forced release (used only with ARB_LOCK_EN)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req  input  R  write request per requester; held high until ack
- in0  input  R*n  packed write data; requester i uses bits [i*n +: n]
- lock  input  R  hold-grant request per requester; ignored unless ARB_LOCK_EN is defined
- gnt  output  R  one-hot grant, registered
- ack  output  R  one-hot write-done pulse, registered
- out0  output  n  shared register contents
- busy  output  1  high while state is GRANT

Behaviour:
- Reset (rst high at a clk edge) has priority over everything, including a write in progress. After reset:
  - out0=0, gnt=0, ack=0, busy=0
  - state=IDLE, round-robin pointer ptr=0, lock counter=0
- ack defaults to 0 every cycle unless set by a write below.
- States: IDLE and GRANT.
- IDLE:
  - If req==0, remain in IDLE.
  - Otherwise pick winner w = the first requester with req set, searching from ptr upward with wrap (ptr, ptr+1, ..., R-1, 0, ..., ptr-1).
  - Next edge: gnt[w]=1, state=GRANT, busy=1.
- GRANT (winner w):
  - If req[w]==1 at the edge:
    - out0 <= in0 slice w.
    - ack[w]=1 for the following cycle. out0 already holds the new value in that cycle.
  - If req[w]==0 (requester withdrew): no write, no ack.
  - In both cases, at the same edge: ptr <= (w+1) mod R, gnt <= 0, state <= IDLE.
- Latency:
  - Request sampled in IDLE at cycle T.
  - gnt high during T+1.
  - out0 updated and ack high during T+2.
  - Peak throughput is one write per 2 cycles; the IDLE cycle carrying ack also re-arbitrates.
- Fairness: a requester that keeps req high is granted within R arbitration rounds.
- Requests arriving during GRANT are not considered until the next IDLE cycle.
- gnt is always one-hot or zero. ack is always one-hot or zero.
- ptr arithmetic is mod R; w=R-1 wraps ptr to 0.

Optional Feature:
- Macro: ARB_LOCK_EN
- Defined:
  - In GRANT, if req[w] and lock[w] are both high and the lock counter is below MAX_LOCK-1, the arbiter writes and stays in GRANT.
  - Each such cycle: out0 loads in0 slice w, ack[w] pulses the next cycle, the counter increments, gnt[w] stays high.
  - A write with lock low, req low, or counter equal to MAX_LOCK-1 releases: normal GRANT exit, counter cleared.
  - ptr advances only on release.
- Not defined: the lock port is unused, no counter is built, and GRANT always lasts exactly one cycle.

Test Plan:
- Reset: drive rst=1 with req=4'b1111 for 2 cycles -> out0=0, gnt=0, ack=0, busy=0; after release, first grant goes to requester 0.
- Single write: req=4'b0100, slice2=16'hBEEF at T -> gnt=4'b0100 at T+1; out0=16'hBEEF and ack=4'b0100 at T+2; ptr=3.
- Round-robin: req=4'b1111 held, slices i=16'h0A0i -> grant order 0,1,2,3,0; out0 sequence 0A00,0A01,0A02,0A03; one write every 2 cycles.
- Withdrawal and wrap: ptr=3, req=4'b1001, then drop req[3] during its GRANT -> no ack, out0 unchanged; next grant goes to requester 0 (ptr wrapped).
- Reset mid-operation: rst=1 in a GRANT cycle with req[1]=1 -> no write, out0=0, no ack the next cycle, state IDLE.
- With ARB_LOCK_EN and MAX_LOCK=8: req[1]=lock[1]=1 held, req[2]=1 -> 8 consecutive ack[1] pulses, forced release, then requester 2 is granted; with lock[1] dropped after 3 writes, release occurs after the 4th write.
